// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned MIN_LEN        = 3;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts the top len bits of a captured word out MSB-first,
// one per clock, with a per-bit valid that doubles as the busy indication.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(DATA_W)-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int unsigned MW = $clog2(DATA_W);
  localparam int unsigned CW = MW + 1;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              req_legal;
  logic [CW-1:0]     req_len;

  always_comb begin
    req_legal = (data_mod_i == '0) || (data_mod_i >= MW'(MIN_LEN));
    req_len   = (data_mod_i == '0) ? CW'(DATA_W) : {1'b0, data_mod_i};
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_val_i && req_legal) begin
            state <= SEND;
            shreg <= data_i;
            cnt   <= req_len;
          end
        end
        SEND: begin
          // cnt holds the number of bits still to drive, including the current one
          if (cnt == CW'(1)) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
          end else begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          shreg <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded from state so the async reset clears the outputs without a clock edge.
  always_comb begin
    ser_data_val_o = (state == SEND);
    busy_o         = (state == SEND);
    ser_data_o     = (state == SEND) ? shreg[DATA_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed and random requests against a queue-based model.
module tb_serializer;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = 4;

  logic          clk_i      = 1'b0;
  logic          arst_n_i   = 1'b0;
  logic [W-1:0]  data_i     = '0;
  logic [MW-1:0] data_mod_i = '0;
  logic          data_val_i = 1'b0;
  logic          ser_data_o;
  logic          ser_data_val_o;
  logic          busy_o;

  serializer #(.DATA_W(W)) dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: the bit on the wire now, plus the bits still waiting behind it.
  bit m_valid = 1'b0;
  bit m_bit   = 1'b0;
  bit m_q[$];
  bit log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int len;
    if (m_valid) begin
      if (m_q.size() == 0) m_valid = 1'b0;
      else                 m_bit   = m_q.pop_front();
    end else if (data_val_i && (data_mod_i == 0 || data_mod_i >= 3)) begin
      len     = (data_mod_i == 0) ? W : int'(data_mod_i);
      m_valid = 1'b1;
      m_bit   = data_i[W-1];
      for (int j = 1; j < len; j++) m_q.push_back(data_i[W-1-j]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    chk("valid", 32'(ser_data_val_o), 32'(m_valid));
    chk("busy",  32'(busy_o),         32'(m_valid));
    chk("bit",   32'(ser_data_o),     32'(m_valid & m_bit));
    if (ser_data_val_o) log_q.push_back(ser_data_o);
  endtask

  task automatic req(input logic [W-1:0] d, input logic [MW-1:0] m, input int hold);
    data_i     = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    repeat (hold) step();
    data_val_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [31:0] log_word(input int n);
    logic [31:0] w;
    w = '0;
    for (int i = log_q.size() - n; i < log_q.size(); i++) w = {w[30:0], log_q[i]};
    return w;
  endfunction

  initial begin
    #12;
    chk("rst_valid", 32'(ser_data_val_o), 32'd0);
    chk("rst_busy",  32'(busy_o),         32'd0);
    chk("rst_bit",   32'(ser_data_o),     32'd0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    idle(2);

    // Full word
    log_q.delete();
    req(16'hA5C3, 4'd0, 1);
    idle(18);
    chk("full_len",  32'(log_q.size()), 32'd16);
    chk("full_word", log_word(16), 32'h0000_A5C3);

    // Partial word
    log_q.delete();
    req(16'hF000, 4'd5, 1);
    idle(8);
    chk("part_len",  32'(log_q.size()), 32'd5);
    chk("part_word", log_word(5), 32'b11110);

    // Illegal lengths held high
    log_q.delete();
    req(16'hFFFF, 4'd1, 10);
    req(16'hFFFF, 4'd2, 10);
    chk("illegal_len", 32'(log_q.size()), 32'd0);

    // Request while busy is dropped
    log_q.delete();
    req(16'hFFFF, 4'd0, 1);
    idle(3);
    req(16'h0000, 4'd3, 1);
    idle(16);
    chk("busy_drop_len",  32'(log_q.size()), 32'd16);
    chk("busy_drop_word", log_word(16), 32'h0000_FFFF);

    // Request held through the last bit: accepted one cycle after busy falls
    log_q.delete();
    req(16'hAAAA, 4'd0, 1);
    data_i     = 16'hE000;
    data_mod_i = 4'd3;
    data_val_i = 1'b1;
    repeat (15) step();
    chk("held_last_bit_busy", 32'(busy_o), 32'd1);
    step();
    chk("held_gap_busy", 32'(busy_o), 32'd0);
    step();
    chk("held_accept_busy", 32'(busy_o), 32'd1);
    data_val_i = 1'b0;
    idle(6);
    chk("held_len",  32'(log_q.size()), 32'd19);
    chk("held_word", log_word(19), {13'd0, 16'hAAAA, 3'b111});

    // Asynchronous reset mid-transfer
    req(16'hB5B5, 4'd0, 1);
    idle(5);
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(ser_data_val_o), 32'd0);
    chk("arst_busy",  32'(busy_o),         32'd0);
    chk("arst_bit",   32'(ser_data_o),     32'd0);
    m_valid = 1'b0;
    m_q.delete();
    @(negedge clk_i);
    arst_n_i = 1'b1;
    log_q.delete();
    idle(1);
    req(16'h8001, 4'd0, 1);
    idle(18);
    chk("post_rst_len",  32'(log_q.size()), 32'd16);
    chk("post_rst_word", log_word(16), 32'h0000_8001);

    // Receiver-side reassembly of a full word
    log_q.delete();
    req(16'h1234, 4'd0, 1);
    idle(17);
    chk("loop_word", log_word(16), 32'h0000_1234);

    // Random traffic, including illegal lengths and requests while busy
    repeat (60) begin
      req(W'($urandom), MW'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
      idle(int'($urandom_range(0, 20)));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
